// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the parametrised register file:
//               default geometry, the architectural register address type,
//               the hardwired-zero address and an address qualification
//               helper used by both the data array and the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int AW            = $clog2(DEFAULT_NREGS);

  typedef logic [AW-1:0] rf_addr_t;

  localparam rf_addr_t ZERO_ADDR = '0;

  // True when an address names a real, writable/trackable register: inside
  // the array and not the hardwired-zero register.
  function automatic logic addr_usable(input int addr, input int nregs,
                                       input logic zero_reg);
    logic is_zero;
    is_zero = zero_reg && (addr == int'(ZERO_ADDR));
    return (addr < nregs) && !is_zero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending-write (busy) bits with flush/set/clear
//               priority and a popcount of outstanding producers.
// Ports       : clk, rst (async, active-high)
//               flush             - clear every busy bit
//               busy_set/busy_addr- mark a register as having a producer
//               wr_en/wr_addr     - writeback retires the producer
//               busy              - registered busy vector
//               busy_count        - number of set busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_count
);

  logic [NREGS-1:0] r_busy;
  logic             w_set_ok;
  logic             w_clr_ok;
  logic [AW:0]      w_count;

  assign w_set_ok = busy_set && addr_usable(int'(busy_addr), NREGS, ZERO_REG != 0);
  assign w_clr_ok = wr_en    && addr_usable(int'(wr_addr),   NREGS, ZERO_REG != 0);

  // The set is applied after the clear so a new producer issued in the same
  // cycle as the old one retires keeps the register pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (w_clr_ok) r_busy[wr_addr]   <= 1'b0;
      if (w_set_ok) r_busy[busy_addr] <= 1'b1;
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_count = w_count + (AW+1)'(r_busy[k]);
    end
  end

  assign busy       = r_busy;
  assign busy_count = w_count;

endmodule
`default_nettype wire

// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : param_register_file
// Description : Parametrised integer register file with NREAD combinational
//               read ports, optional write-to-read bypass, optional
//               hardwired-zero register and a pending-write scoreboard that
//               flags RAW hazards against in-flight producers.
// Ports       : clk, rst (async, active-high)
//               wr_en/wr_addr/wr_data - writeback port (also clears busy)
//               rd_en/rd_addr         - per-port valid and packed addresses
//               rd_data/rd_busy       - packed read data, per-port hazard
//               stall                 - any enabled port sees a hazard
//               busy_set/busy_addr    - decode marks a pending destination
//               flush                 - clears all busy bits
//               busy_count            - number of pending registers
// Revision    : 1.0 - initial release
// ============================================================================
module param_register_file
  import rf_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NREAD-1:0]    rd_en,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]    rd_busy,
  output logic                stall,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  input  logic                flush,
  output logic [AW:0]         busy_count
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_wr_ok;

  assign w_wr_ok = wr_en && addr_usable(int'(wr_addr), NREGS, ZERO_REG != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .busy_set   (busy_set),
    .busy_addr  (busy_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (w_busy),
    .busy_count (busy_count)
  );

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_usable;
      logic          w_fwd;

      assign w_addr   = rd_addr[i*AW +: AW];
      assign w_usable = addr_usable(int'(w_addr), NREGS, ZERO_REG != 0);
      // Forwarding also hides the hazard: the producer's value is on the bus.
      assign w_fwd    = (BYPASS != 0) && wr_en && (wr_addr == w_addr);

      assign rd_data[i*XLEN +: XLEN] = !w_usable ? '0      :
                                       w_fwd     ? wr_data :
                                                   r_regs[w_addr];
      assign rd_busy[i] = w_usable && !w_fwd && w_busy[w_addr];
    end
  endgenerate

  assign stall = |(rd_en & rd_busy);

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_register_file
// Description : Self-checking bench. Two instances share the write and
//               scoreboard stimulus: A is the default 32x32, 2-port, bypass
//               configuration; B is 24 registers, 3 ports, no bypass. Both are
//               compared every cycle against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic        flush;

  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_stall;
  logic [5:0]  a_busy_count;

  logic [2:0]  b_rd_en;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_stall;
  logic [5:0]  b_busy_count;

  param_register_file #(
    .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .stall(a_stall), .busy_set(busy_set),
    .busy_addr(busy_addr), .flush(flush), .busy_count(a_busy_count)
  );

  param_register_file #(
    .XLEN(32), .NREGS(24), .NREAD(3), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .stall(b_stall), .busy_set(busy_set),
    .busy_addr(busy_addr), .flush(flush), .busy_count(b_busy_count)
  );

  int checks   = 0;
  int failures = 0;

  int   cfg_nregs [2] = '{32, 24};
  bit   cfg_byp   [2] = '{1'b1, 1'b0};
  int   cfg_nrd   [2] = '{2, 3};

  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];
  int          ra     [2][4];
  bit          re     [2][4];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit usable(int d, int a);
    return (a < cfg_nregs[d]) && (a != 0);
  endfunction

  function automatic logic [31:0] exp_data(int d, int a);
    if (!usable(d, a)) return 32'h0;
    if (cfg_byp[d] && wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[d][a];
  endfunction

  function automatic bit exp_busy(int d, int a);
    if (!usable(d, a)) return 1'b0;
    if (cfg_byp[d] && wr_en && int'(wr_addr) == a) return 1'b0;
    return m_busy[d][a];
  endfunction

  function automatic int exp_count(int d);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[d][r]);
    return n;
  endfunction

  task automatic apply_rd();
    for (int p = 0; p < 2; p++) begin
      a_rd_addr[p*5 +: 5] = 5'(ra[0][p]);
      a_rd_en[p]          = re[0][p];
    end
    for (int p = 0; p < 3; p++) begin
      b_rd_addr[p*5 +: 5] = 5'(ra[1][p]);
      b_rd_en[p]          = re[1][p];
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) begin
        m_regs[d][r] = '0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit st = 1'b0;
      string nm = (d == 0) ? "A" : "B";
      for (int p = 0; p < cfg_nrd[d]; p++) begin
        logic [31:0] gd = (d == 0) ? a_rd_data[p*32 +: 32] : b_rd_data[p*32 +: 32];
        logic        gb = (d == 0) ? a_rd_busy[p] : b_rd_busy[p];
        chk($sformatf("%s.rd_data%0d[r%0d]", nm, p, ra[d][p]), 96'(gd), 96'(exp_data(d, ra[d][p])));
        chk($sformatf("%s.rd_busy%0d[r%0d]", nm, p, ra[d][p]), 96'(gb), 96'(exp_busy(d, ra[d][p])));
        st |= re[d][p] && exp_busy(d, ra[d][p]);
      end
      chk({nm, ".stall"}, 96'((d == 0) ? a_stall : b_stall), 96'(st));
      chk({nm, ".busy_count"}, 96'((d == 0) ? a_busy_count : b_busy_count), 96'(exp_count(d)));
    end
  endtask

  task automatic update_model();
    if (rst) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[d][r] = 1'b0;
      end else begin
        if (wr_en && usable(d, int'(wr_addr)))      m_busy[d][wr_addr]   = 1'b0;
        if (busy_set && usable(d, int'(busy_addr))) m_busy[d][busy_addr] = 1'b1;
      end
      if (wr_en && usable(d, int'(wr_addr))) m_regs[d][wr_addr] = wr_data;
    end
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; busy_set = 1'b0; flush = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 4; p++) re[d][p] = 1'b0;
    apply_rd();
  endtask

  task automatic do_write(input int a, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = v;
  endtask

  task automatic do_set(input int a);
    busy_set = 1'b1; busy_addr = 5'(a);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 4; p++) ra[d][p] = 0;
    model_clear();
    rst = 1'b1; wr_addr = '0; wr_data = '0; busy_addr = '0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset asserted between edges while state is live
    do_write(5, 32'hDEADBEEF); step(); idle();
    do_set(7); step(); idle();
    ra[0][0] = 5; ra[0][1] = 7; re[0][1] = 1'b1; apply_rd();
    #1;
    chk("pre_rst.r5", 96'(a_rd_data[31:0]), 96'h0DEADBEEF);
    chk("pre_rst.r7_busy", 96'(a_rd_busy[1]), 96'h1);
    #1 rst = 1'b1;
    model_clear();
    #1;
    chk("rst.r5", 96'(a_rd_data[31:0]), 96'h0);
    chk("rst.r7_busy", 96'(a_rd_busy[1]), 96'h0);
    chk("rst.stall", 96'(a_stall), 96'h0);
    chk("rst.count", 96'(a_busy_count), 96'h0);
    step();
    rst = 1'b0;
    idle();

    // Zero register ignores writes and busy marks
    do_write(0, 32'hFFFFFFFF); do_set(0);
    ra[0][0] = 0; re[0][0] = 1'b1; apply_rd();
    #1;
    chk("zero.data", 96'(a_rd_data[31:0]), 96'h0);
    chk("zero.busy", 96'(a_rd_busy[0]), 96'h0);
    step(); idle();
    #1;
    chk("zero.count", 96'(a_busy_count), 96'h0);
    chk("zero.data_after", 96'(a_rd_data[31:0]), 96'h0);

    // Bypass versus no bypass on a busy register
    do_set(3); step(); idle();
    do_write(3, 32'h12345678);
    ra[0][1] = 3; re[0][1] = 1'b1; ra[1][1] = 3; re[1][1] = 1'b1; apply_rd();
    #1;
    chk("byp.A_data", 96'(a_rd_data[63:32]), 96'h12345678);
    chk("byp.A_busy", 96'(a_rd_busy[1]), 96'h0);
    chk("nobyp.B_data", 96'(b_rd_data[63:32]), 96'h0);
    chk("nobyp.B_busy", 96'(b_rd_busy[1]), 96'h1);
    step();
    wr_en = 1'b0;
    #1;
    chk("nobyp.B_data_next", 96'(b_rd_data[63:32]), 96'h12345678);
    chk("nobyp.B_busy_next", 96'(b_rd_busy[1]), 96'h0);
    step(); idle();

    // Set and clear of the same register in one cycle
    do_set(9); step(); idle();
    do_set(9); do_write(9, 32'hA5); step(); idle();
    ra[0][0] = 9; re[0][0] = 1'b1; apply_rd();
    #1;
    chk("race.data", 96'(a_rd_data[31:0]), 96'hA5);
    chk("race.busy", 96'(a_rd_busy[0]), 96'h1);
    chk("race.stall", 96'(a_stall), 96'h1);
    step(); idle();

    // Flush wins over a same-cycle set
    flush = 1'b1; step(); idle();
    do_set(1); step(); do_set(2); step(); do_set(4); step(); idle();
    #1;
    chk("flush.count3_A", 96'(a_busy_count), 96'h3);
    chk("flush.count3_B", 96'(b_busy_count), 96'h3);
    flush = 1'b1; do_set(6); step(); idle();
    ra[0][0] = 6; ra[0][1] = 3; apply_rd();
    #1;
    chk("flush.count0", 96'(a_busy_count), 96'h0);
    chk("flush.r6_busy", 96'(a_rd_busy[0]), 96'h0);
    chk("flush.r3_data", 96'(a_rd_data[63:32]), 96'h12345678);
    step();

    // Non-power-of-two depth on instance B
    do_write(30, 32'h77); step(); idle();
    ra[1][0] = 30; apply_rd();
    #1;
    chk("np2.r30", 96'(b_rd_data[31:0]), 96'h0);
    do_write(10, 32'h0A10); step(); do_write(23, 32'h0B23); step(); idle();
    ra[1][0] = 10; ra[1][1] = 10; ra[1][2] = 23; apply_rd();
    #1;
    chk("np2.multi", b_rd_data, {32'h0B23, 32'h0A10, 32'h0A10});
    step();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      busy_set  = ($urandom_range(0, 2) != 0);
      busy_addr = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 19) == 0);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 4; p++) begin
          // Bias some reads toward the write target to exercise forwarding.
          ra[d][p] = ($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'($urandom_range(0, 31));
          re[d][p] = ($urandom_range(0, 1) == 1);
        end
      apply_rd();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
